alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the MIPS datapath; next generation of the single-cycle ALU.

---
 rtl/alu_mc.sv | 215 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle MIPS EX-stage ALU with iterative unsigned multiply/divide
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OPW-1:0]   operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [OPW-1:0] OP_AND  = OPW'(4'b0000);
   localparam logic [OPW-1:0] OP_OR   = OPW'(4'b0001);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0010);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4'b0110);
   localparam logic [OPW-1:0] OP_SLT  = OPW'(4'b0111);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(4'b1000);
   localparam logic [OPW-1:0] OP_NOR  = OPW'(4'b1001);
   localparam logic [OPW-1:0] OP_SLTU = OPW'(4'b1010);
   localparam logic [OPW-1:0] OP_MULU = OPW'(4'b1100);
   localparam logic [OPW-1:0] OP_DIVU = OPW'(4'b1101);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             dbz_pend_q, dbz_pend_d;
   // opnd holds the multiplicand (MULU) or the divisor (DIVU)
   logic [WIDTH-1:0] opnd_q, opnd_d;
   // hi is the product accumulator / partial remainder, lo is multiplier / dividend-quotient
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] b_neg;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n;
   logic [WIDTH-1:0] mul_lo_n;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_trial;
   logic             rem_ge;
   logic [WIDTH-1:0] div_hi_n;
   logic [WIDTH-1:0] div_lo_n;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   assign busy        = (state_q == S_RUN);
   assign done        = done_q;
   assign result      = result_q;
   assign result_hi   = result_hi_q;
   assign zero        = zero_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;

   // single-cycle operations evaluated straight from the live inputs
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      sum     = a + b;
      diff    = a - b;
      b_neg   = ~b + 1'b1;
      case (operation)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] == b_neg[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_res = '0;
      endcase
   end

   // one shift-add (multiply) and one restoring shift-subtract (divide) step
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_hi_n  = mul_sum[WIDTH:1];
      mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
      rem_sh    = {hi_q, lo_q[WIDTH-1]};
      rem_ge    = (rem_sh >= {1'b0, opnd_q});
      // when rem_ge holds the difference is below the divisor, so WIDTH bits suffice;
      // a zero divisor always subtracts, giving all-ones quotient and remainder == a
      rem_trial = rem_sh[WIDTH-1:0] - opnd_q;
      div_hi_n  = rem_ge ? rem_trial : rem_sh[WIDTH-1:0];
      div_lo_n  = {lo_q[WIDTH-2:0], rem_ge};
      step_hi   = is_div_q ? div_hi_n : mul_hi_n;
      step_lo   = is_div_q ? div_lo_n : mul_lo_n;
   end

   // next-state and output-register logic of the IDLE/RUN controller
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      dbz_pend_d  = dbz_pend_q;
      opnd_d      = opnd_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (operation == OP_MULU) begin
                  state_d    = S_RUN;
                  cnt_d      = '0;
                  is_div_d   = 1'b0;
                  dbz_pend_d = 1'b0;
                  opnd_d     = a;
                  hi_d       = '0;
                  lo_d       = b;
               end else if (operation == OP_DIVU) begin
                  state_d    = S_RUN;
                  cnt_d      = '0;
                  is_div_d   = 1'b1;
                  dbz_pend_d = (b == '0);
                  opnd_d     = b;
                  hi_d       = '0;
                  lo_d       = a;
               end else begin
                  result_d    = alu_res;
                  result_hi_d = '0;
                  zero_d      = (alu_res == '0);
                  ovf_d       = alu_ovf;
                  dbz_d       = 1'b0;
                  done_d      = 1'b1;
               end
            end
         end
         S_RUN: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               result_d    = step_lo;
               result_hi_d = step_hi;
               zero_d      = (step_lo == '0);
               ovf_d       = 1'b0;
               dbz_d       = is_div_q && dbz_pend_q;
               done_d      = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers; reset aborts any op in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         dbz_pend_q  <= 1'b0;
         opnd_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_div_q    <= is_div_d;
         dbz_pend_q  <= dbz_pend_d;
         opnd_q      <= opnd_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;
   localparam logic [3:0] OP_BAD  = 4'b0011;
   localparam logic [3:0] OP_MULU = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  operation = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, zero, overflow, div_by_zero;
   logic [31:0] result, result_hi;

   int n_checks = 0;
   int n_fail   = 0;
   int lat, bcy, dcnt;

   alu_mc #(.WIDTH(32), .OPW(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
      .a(a), .b(b), .busy(busy), .done(done), .result(result),
      .result_hi(result_hi), .zero(zero), .overflow(overflow),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // returns at the negedge following the sampling edge
   task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      start = 1'b1; operation = op; a = va; b = vb;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int latency, output int busy_cycles, output int dones);
      latency = -1; busy_cycles = 0; dones = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy) busy_cycles++;
         if (done) begin dones++; latency = i; break; end
         @(negedge clk);
      end
   endtask

   task automatic single(input string tag, input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] er, input logic ez,
                         input logic eo);
      issue(op, va, vb);
      chk({tag, ".done"}, {31'b0, done}, 32'd1);
      chk({tag, ".result"}, result, er);
      chk({tag, ".hi"}, result_hi, 32'd0);
      chk({tag, ".zero"}, {31'b0, zero}, {31'b0, ez});
      chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, eo});
      @(negedge clk);
      chk({tag, ".done_off"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst.busy", {31'b0, busy}, 32'd0);
      chk("rst.done", {31'b0, done}, 32'd0);
      chk("rst.result", result, 32'd0);
      chk("rst.hi", result_hi, 32'd0);
      chk("rst.flags", {29'b0, zero, overflow, div_by_zero}, 32'd0);
      rst_n = 1'b1;

      single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
      single("sub_zero", OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
      single("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
      single("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
      single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
      single("nor", OP_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      single("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
      single("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
      single("badop", OP_BAD, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b0);

      issue(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mul.busy_now", {31'b0, busy}, 32'd1);
      wait_done(lat, bcy, dcnt);
      chk("mul.dones", dcnt, 32'd1);
      chk("mul.latency", lat, 32'd32);
      chk("mul.busy_cycles", bcy, 32'd32);
      chk("mul.lo", result, 32'h0000_0001);
      chk("mul.hi", result_hi, 32'hFFFF_FFFE);
      chk("mul.busy_end", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("mul.done_off", {31'b0, done}, 32'd0);

      issue(OP_DIVU, 32'd100, 32'd7);
      wait_done(lat, bcy, dcnt);
      chk("div.dones", dcnt, 32'd1);
      chk("div.latency", lat, 32'd32);
      chk("div.q", result, 32'd14);
      chk("div.r", result_hi, 32'd2);
      chk("div.dbz", {31'b0, div_by_zero}, 32'd0);

      issue(OP_DIVU, 32'h1234, 32'd0);
      wait_done(lat, bcy, dcnt);
      chk("div0.latency", lat, 32'd32);
      chk("div0.q", result, 32'hFFFF_FFFF);
      chk("div0.r", result_hi, 32'h1234);
      chk("div0.dbz", {31'b0, div_by_zero}, 32'd1);

      // start pulsed mid-MULU must be ignored; outputs hold meanwhile
      issue(OP_MULU, 32'd3, 32'd5);
      @(negedge clk);
      start = 1'b1; operation = OP_ADD; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0; operation = OP_SUB; a = 32'd7; b = 32'd9;
      chk("ign.done", {31'b0, done}, 32'd0);
      chk("ign.hold", result, 32'hFFFF_FFFF);
      chk("ign.busy", {31'b0, busy}, 32'd1);
      wait_done(lat, bcy, dcnt);
      chk("ign.latency", lat, 32'd30);
      chk("ign.lo", result, 32'd15);
      chk("ign.hi", result_hi, 32'd0);
      // back-to-back issue in the done cycle
      start = 1'b1; operation = OP_ADD; a = 32'd2; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      chk("b2b.done", {31'b0, done}, 32'd1);
      chk("b2b.result", result, 32'd5);
      @(negedge clk);
      chk("b2b.done_off", {31'b0, done}, 32'd0);

      // reset during DIVU step 10
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      chk("abort.busy_pre", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", {31'b0, busy}, 32'd0);
      chk("abort.result", result, 32'd0);
      chk("abort.hi", result_hi, 32'd0);
      chk("abort.done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("abort.no_done", dcnt, 32'd0);
      single("post_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
